// File: rtl/pwm_pkg.sv
// Shared definitions for the high-resolution PWM path: default widths and the
// settings bundle exchanged between the period controller and the output-compare stage.
package pwm_pkg;

  localparam int PWM_WIDTH  = 17;
  localparam int PWM_HRBITS = 3;
  localparam int PWM_DBITS  = 8;
  localparam int CW         = PWM_WIDTH - PWM_HRBITS;

  typedef struct packed {
    logic [CW-1:0]                  period;
    logic [PWM_WIDTH-1:0]           phase;
    logic [PWM_WIDTH+PWM_DBITS-1:0] duty;
  } pwm_cfg_t;

endpackage

// File: rtl/pwm_dither_acc.sv
// First-order sigma-delta accumulator: carry out on the step where the
// fractional duty accumulation crosses one fine LSB.
module pwm_dither_acc #(
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [DBITS-1:0] frac,
  output logic             carry,
  output logic [DBITS-1:0] acc
);

  logic [DBITS:0] sum;

  assign sum   = {1'b0, acc} + {1'b0, frac};
  assign carry = sum[DBITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (step) begin
      acc <= sum[DBITS-1:0];
    end
  end

endmodule

// File: rtl/pwm_period_ctrl.sv
// Coarse timebase plus double-buffered period/phase/duty settings, producing the
// fine rising/falling compare words for the output-compare stage once per period.
module pwm_period_ctrl
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int HRBITS   = PWM_HRBITS,
  parameter int DBITS    = PWM_DBITS,
  parameter int PER_RST  = 100,
  parameter int DUTY_RST = 50
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WIDTH-HRBITS-1:0]  wr_period,
  input  logic [WIDTH-1:0]         wr_phase,
  input  logic [WIDTH+DBITS-1:0]   wr_duty,
  output logic [WIDTH-HRBITS-1:0]  tb,
  output logic [WIDTH-1:0]         cmpH,
  output logic [WIDTH-1:0]         cmpL,
  output logic                     wrap,
  output logic                     upd_ack
);

  localparam int TW = WIDTH - HRBITS;
  localparam int DW = WIDTH + DBITS;

  typedef struct packed {
    logic [TW-1:0]    period;
    logic [WIDTH-1:0] phase;
    logic [DW-1:0]    duty;
  } cfg_t;

  // Duty saturation: a high time of a full period or more is held at P-1.
  function automatic logic [WIDTH-1:0] sat_duty(input logic [WIDTH:0] d,
                                                input logic [WIDTH-1:0] p);
    if (d >= {1'b0, p}) return p - WIDTH'(1);
    return d[WIDTH-1:0];
  endfunction

  // Single conditional subtract; callers guarantee x < 2P.
  function automatic logic [WIDTH-1:0] mod_once(input logic [WIDTH:0] x,
                                                input logic [WIDTH-1:0] p);
    if (x >= {1'b0, p}) return WIDTH'(x - {1'b0, p});
    return x[WIDTH-1:0];
  endfunction

  cfg_t             act;
  cfg_t             shd;
  cfg_t             nxt;
  logic             pending;
  logic             accept;
  logic             wrap_i;
  logic [TW-1:0]    per_wr;

  logic             carry;
  logic [DBITS-1:0] acc;

  logic [WIDTH-1:0] p_p0;
  logic [WIDTH:0]   d_raw_p0;
  logic [WIDTH-1:0] d_p0;
  logic [WIDTH-1:0] ph_p0;
  logic [WIDTH:0]   sum_p0;
  logic [WIDTH-1:0] cl_p0;

  assign wr_ready = !pending;
  assign accept   = wr_valid && wr_ready;
  assign per_wr   = (wr_period < TW'(2)) ? TW'(2) : wr_period;
  assign wrap_i   = (tb == act.period - TW'(1));
  assign wrap     = wrap_i;

  // Settings that govern the period starting at the next wrap edge.
  assign nxt = pending ? shd : act;

  always_ff @(posedge clk) begin
    if (accept) begin
      shd <= '{period: per_wr, phase: wr_phase, duty: wr_duty};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
      upd_ack <= 1'b0;
      tb      <= '0;
      act     <= '{period: TW'(PER_RST), phase: '0, duty: DW'(DUTY_RST) << DBITS};
    end else begin
      upd_ack <= wrap_i && pending;
      tb      <= wrap_i ? '0 : tb + TW'(1);
      if (wrap_i && pending) begin
        act <= shd;
      end
      if (accept) begin
        pending <= 1'b1;
      end else if (wrap_i) begin
        pending <= 1'b0;
      end
    end
  end

  pwm_dither_acc #(
    .DBITS (DBITS)
  ) u_dither (
    .clk   (clk),
    .rst   (rst),
    .step  (wrap_i),
    .frac  (nxt.duty[DBITS-1:0]),
    .carry (carry),
    .acc   (acc)
  );

  // Stage p0: compare words computed from the upcoming settings
  assign p_p0     = {nxt.period, {HRBITS{1'b0}}};
  assign d_raw_p0 = {1'b0, nxt.duty[DW-1:DBITS]} + (WIDTH+1)'(carry);
  assign d_p0     = sat_duty(d_raw_p0, p_p0);
  assign ph_p0    = mod_once({1'b0, nxt.phase}, p_p0);
  assign sum_p0   = {1'b0, ph_p0} + {1'b0, d_p0};
  assign cl_p0    = mod_once(sum_p0, p_p0);

  // Stage p1: compare words held for the whole period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmpH <= '0;
      cmpL <= WIDTH'(DUTY_RST);
    end else if (wrap_i) begin
      cmpH <= ph_p0;
      cmpL <= cl_p0;
    end
  end

endmodule

// File: tb/tb_pwm_period_ctrl.sv
// Directed bench for pwm_period_ctrl: timebase, double-buffered updates,
// dither sequence, compare wraparound, duty clamp and reset behaviour.
module tb_pwm_period_ctrl;

  localparam int WIDTH  = 17;
  localparam int HRBITS = 3;
  localparam int DBITS  = 8;
  localparam int CW     = WIDTH - HRBITS;

  logic                   clk;
  logic                   rst;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [CW-1:0]          wr_period;
  logic [WIDTH-1:0]       wr_phase;
  logic [WIDTH+DBITS-1:0] wr_duty;
  logic [CW-1:0]          tb;
  logic [WIDTH-1:0]       cmpH;
  logic [WIDTH-1:0]       cmpL;
  logic                   wrap;
  logic                   upd_ack;

  int vectors = 0;
  int errors  = 0;

  pwm_period_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_period (wr_period),
    .wr_phase  (wr_phase),
    .wr_duty   (wr_duty),
    .tb        (tb),
    .cmpH      (cmpH),
    .cmpL      (cmpL),
    .wrap      (wrap),
    .upd_ack   (upd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until the first cycle of a new period (tb==0), bounded.
  task automatic wait_wrap();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (tb == '0) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL wait_wrap timeout: tb=%0d, required tb=0 within 1000 cycles", tb);
    end
  endtask

  task automatic write_cfg(input logic [CW-1:0] per, input logic [WIDTH-1:0] ph,
                           input logic [WIDTH+DBITS-1:0] du);
    wr_valid  = 1'b1;
    wr_period = per;
    wr_phase  = ph;
    wr_duty   = du;
    step();
    wr_valid  = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (tb !== '0 || wr_ready !== 1'b1 || cmpL !== 17'd50) begin
      errors++;
      $display("FAIL reset_hold: tb=%0d rdy=%0b cmpL=%0d, required 0 1 50", tb, wr_ready, cmpL);
    end
    rst = 1'b0;
    vectors++;
    if (tb !== '0 || wrap !== 1'b0 || upd_ack !== 1'b0 || cmpH !== '0 || cmpL !== 17'd50) begin
      errors++;
      $display("FAIL reset_state: tb=%0d wrap=%0b ack=%0b cmpH=%0d cmpL=%0d, required 0 0 0 0 50",
               tb, wrap, upd_ack, cmpH, cmpL);
    end
    cnt = 0;
    while (wrap !== 1'b1 && cnt < 300) begin
      step();
      cnt++;
    end
    vectors++;
    if (cnt != 99 || tb !== 14'd99) begin
      errors++;
      $display("FAIL first_wrap: steps=%0d tb=%0d, required 99 99", cnt, tb);
    end
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (wrap !== 1'b1 && cnt < 300);
    vectors++;
    if (cnt != 100) begin
      errors++;
      $display("FAIL reset_period: interval=%0d, required 100", cnt);
    end
    vectors++;
    if (cmpH !== '0 || cmpL !== 17'd50) begin
      errors++;
      $display("FAIL reset_cmp: cmpH=%0d cmpL=%0d, required 0 50", cmpH, cmpL);
    end
  endtask

  task automatic test_update();
    int cnt;
    step();
    while (tb != 14'd10) step();
    vectors++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_write: wr_ready=%0b, required 1", wr_ready);
    end
    write_cfg(14'd40, 17'd16, 25'(80) << 8);
    vectors++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_write: wr_ready=%0b, required 0", wr_ready);
    end
    cnt = 0;
    while (wrap !== 1'b1 && cnt < 300) begin
      vectors++;
      if (upd_ack !== 1'b0 || cmpL !== 17'd50) begin
        errors++;
        $display("FAIL early_update: ack=%0b cmpL=%0d at tb=%0d, required 0 50", upd_ack, cmpL, tb);
      end
      step();
      cnt++;
    end
    step();
    vectors++;
    if (tb !== '0 || upd_ack !== 1'b1 || cmpH !== 17'd16 || cmpL !== 17'd96 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL update_apply: tb=%0d ack=%0b cmpH=%0d cmpL=%0d rdy=%0b, required 0 1 16 96 1",
               tb, upd_ack, cmpH, cmpL, wr_ready);
    end
    cnt = 0;
    while (wrap !== 1'b1 && cnt < 300) begin
      step();
      cnt++;
    end
    vectors++;
    if (cnt != 39 || tb !== 14'd39) begin
      errors++;
      $display("FAIL new_period: steps=%0d tb=%0d, required 39 39", cnt, tb);
    end
    step();
    vectors++;
    if (upd_ack !== 1'b0 || cmpH !== 17'd16 || cmpL !== 17'd96) begin
      errors++;
      $display("FAIL ack_pulse: ack=%0b cmpH=%0d cmpL=%0d, required 0 16 96", upd_ack, cmpH, cmpL);
    end
  endtask

  task automatic test_dither();
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] exp_diff;
    write_cfg(14'd40, 17'd0, (25'(10) << 8) | 25'h40);
    for (int i = 0; i < 8; i++) begin
      wait_wrap();
      diff     = cmpL - cmpH;
      exp_diff = (i % 4 == 3) ? 17'd11 : 17'd10;
      vectors++;
      if (diff !== exp_diff) begin
        errors++;
        $display("FAIL dither_period%0d: cmpL-cmpH=%0d, required %0d", i, diff, exp_diff);
      end
    end
  endtask

  task automatic test_wraparound();
    write_cfg(14'd40, 17'd300, 25'(40) << 8);
    wait_wrap();
    vectors++;
    if (upd_ack !== 1'b1 || cmpH !== 17'd300 || cmpL !== 17'd20) begin
      errors++;
      $display("FAIL phase_wrap: ack=%0b cmpH=%0d cmpL=%0d, required 1 300 20", upd_ack, cmpH, cmpL);
    end
  endtask

  task automatic test_clamp();
    write_cfg(14'd40, 17'd0, 25'(500) << 8);
    wait_wrap();
    vectors++;
    if (cmpH !== '0 || cmpL !== 17'd319) begin
      errors++;
      $display("FAIL duty_clamp: cmpH=%0d cmpL=%0d, required 0 319", cmpH, cmpL);
    end
    write_cfg(14'd1, 17'd0, 25'(40) << 8);
    wait_wrap();
    vectors++;
    if (cmpH !== '0 || cmpL !== 17'd15) begin
      errors++;
      $display("FAIL min_period_clamp: cmpH=%0d cmpL=%0d, required 0 15", cmpH, cmpL);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (tb !== 14'(i % 2) || wrap !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL min_period_tb%0d: tb=%0d wrap=%0b, required %0d %0b",
                 i, tb, wrap, i % 2, (i % 2 == 1));
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    cnt = 0;
    while (wrap !== 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
    vectors++;
    if (wrap !== 1'b1 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wrap_write_setup: wrap=%0b rdy=%0b, required 1 1", wrap, wr_ready);
    end
    write_cfg(14'd20, 17'd8, 25'(24) << 8);
    vectors++;
    if (tb !== '0 || upd_ack !== 1'b0 || cmpL !== 17'd15 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL wrap_write_deferred: tb=%0d ack=%0b cmpL=%0d rdy=%0b, required 0 0 15 0",
               tb, upd_ack, cmpL, wr_ready);
    end
    wait_wrap();
    vectors++;
    if (upd_ack !== 1'b1 || cmpH !== 17'd8 || cmpL !== 17'd32) begin
      errors++;
      $display("FAIL wrap_write_apply: ack=%0b cmpH=%0d cmpL=%0d, required 1 8 32", upd_ack, cmpH, cmpL);
    end
  endtask

  task automatic test_reset_pending();
    int acks;
    int wrap_at;
    write_cfg(14'd30, 17'd0, 25'(12) << 8);
    vectors++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL pending_set: wr_ready=%0b, required 0", wr_ready);
    end
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (tb !== '0 || wr_ready !== 1'b1 || cmpH !== '0 || cmpL !== 17'd50) begin
      errors++;
      $display("FAIL async_reset: tb=%0d rdy=%0b cmpH=%0d cmpL=%0d, required 0 1 0 50",
               tb, wr_ready, cmpH, cmpL);
    end
    step();
    rst = 1'b0;
    acks    = 0;
    wrap_at = -1;
    for (int i = 0; i < 101; i++) begin
      if (upd_ack === 1'b1) acks++;
      if (wrap === 1'b1 && wrap_at < 0) wrap_at = i;
      step();
    end
    vectors++;
    if (acks != 0 || wrap_at != 99) begin
      errors++;
      $display("FAIL reset_drops_pending: acks=%0d first_wrap=%0d, required 0 99", acks, wrap_at);
    end
    vectors++;
    if (cmpH !== '0 || cmpL !== 17'd50) begin
      errors++;
      $display("FAIL reset_restore_cmp: cmpH=%0d cmpL=%0d, required 0 50", cmpH, cmpL);
    end
  endtask

  initial begin
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_period = '0;
    wr_phase  = '0;
    wr_duty   = '0;
    test_reset();
    test_update();
    test_dither();
    test_wraparound();
    test_clamp();
    test_back_to_back();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
